bram_rd_addr_gen: RTL

Parametrised BRAM port-B read address generator; successor to the fixed 9-bit free-running read address counter.
- Adds a run-time programmable window (base, length, stride), one-shot and continuous-wrap modes, and a start/abort/done handshake.
- Adds a read-data-valid strobe delayed by the BRAM read latency.
- Sits between the read-side controller and the BRAM port-B address/enable pins.

---
 rtl/bram_rd_addr_gen_pkg.sv | 22 ++
 rtl/bram_lat_pipe.sv | 42 ++++
 rtl/bram_rd_addr_gen.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bram_rd_addr_gen_pkg.sv
// ============================================================================
// Module   : bram_rd_addr_gen_pkg
// Purpose  : Shared defaults and state encoding for the BRAM port-B read
//            address generator and its helpers.
// Contents : DEF_ADDR_W, DEF_READ_LAT, state_t (ST_IDLE / ST_RUN)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_rd_addr_gen_pkg;

    localparam int DEF_ADDR_W   = 9;
    localparam int DEF_READ_LAT = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bram_lat_pipe.sv
// ============================================================================
// Module   : bram_lat_pipe
// Purpose  : DEPTH-stage 1-bit shift register used to align a strobe with
//            the BRAM read latency (also used on the write side).
// Ports    : CLK   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            din   - strobe in
//            dout  - strobe delayed by DEPTH cycles
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= din;
            end
        end else begin : g_multi
            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= {r_sr[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = r_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/bram_rd_addr_gen.sv
// ============================================================================
// Module   : bram_rd_addr_gen
// Purpose  : BRAM port-B read address generator with programmable window
//            (base, length, stride), one-shot / continuous-wrap modes,
//            start/abort/done handshake and a latency-aligned data-valid.
// Ports    : CLK, rst_n                 - clock / async active-low reset
//            cfg_base/len/stride/wrap   - window config, sampled on start
//            start, abort               - single-cycle requests
//            adv                        - consumer accepts current address
//            ADDR_B, addr_vld           - BRAM address and its valid
//            rd_data_vld                - BRAM data valid (READ_LAT later)
//            busy, done, wrap_p         - status / one-cycle pulses
//            beat_cnt                   - beats accepted in current pass
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rd_addr_gen
    import bram_rd_addr_gen_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic              cfg_wrap,
    input  logic              start,
    input  logic              abort,
    input  logic              adv,
    output logic [ADDR_W-1:0] ADDR_B,
    output logic              addr_vld,
    output logic              rd_data_vld,
    output logic              busy,
    output logic              done,
    output logic              wrap_p,
    output logic [ADDR_W:0]   beat_cnt
);

    localparam logic [ADDR_W:0] C_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [ADDR_W:0]   r_cnt,   w_cnt_nxt;
    logic              r_done,  w_done_nxt;
    logic              r_wrap_p, w_wrap_p_nxt;
    logic              w_load;

    // Shadow copy of the window, frozen for the whole run
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_stride;
    logic              r_wrap;

    logic w_accept;
    logic w_last;

    assign w_accept = (r_state == ST_RUN) && adv;
    assign w_last   = (r_cnt == (r_len - C_ONE));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_wrap_p <= 1'b0;
            r_base   <= '0;
            r_len    <= '0;
            r_stride <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_wrap_p <= w_wrap_p_nxt;
            if (w_load) begin
                r_base   <= cfg_base;
                r_len    <= cfg_len;
                r_stride <= cfg_stride;
                r_wrap   <= cfg_wrap;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 1'b0;
        w_wrap_p_nxt = 1'b0;
        w_load       = 1'b0;

        // abort outranks everything, including a coincident start;
        // the address is deliberately left where it stopped
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_len != '0) begin
                            w_load      = 1'b1;
                            w_addr_nxt  = cfg_base;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_RUN;
                        end else begin
                            // empty window: report completion without issuing
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (adv) begin
                        if (w_last) begin
                            if (r_wrap) begin
                                w_addr_nxt   = r_base;
                                w_cnt_nxt    = '0;
                                w_wrap_p_nxt = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_cnt_nxt   = r_cnt + C_ONE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            // same-width add truncates modulo BRAM depth
                            w_addr_nxt = r_addr + r_stride;
                            w_cnt_nxt  = r_cnt + C_ONE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Not flushed by abort or pass end: beats already issued still return data
    bram_lat_pipe #(
        .DEPTH (READ_LAT)
    ) u_lat_pipe (
        .CLK   (CLK),
        .rst_n (rst_n),
        .din   (w_accept),
        .dout  (rd_data_vld)
    );

    assign ADDR_B   = r_addr;
    assign busy     = (r_state == ST_RUN);
    assign addr_vld = (r_state == ST_RUN);
    assign done     = r_done;
    assign wrap_p   = r_wrap_p;
    assign beat_cnt = r_cnt;

endmodule

`default_nettype wire
